ex_mem_reg: RTL

EX/MEM pipeline latch for the 5-stage MIPS core; consumes the execute-stage results derived from ID/EX outputs and feeds the memory stage and data cache. It also owns the data-memory request: the dmemREN/dmemWEN strobes stay asserted until dhit and then drop. The block reports busy so the hazard unit can stall upstream. Load data is captured on dhit and held until the next advance.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/ex_mem_if.sv | 34 +++
 rtl/dmem_req_fsm.sv | 30 +++
 rtl/ex_mem_reg.sv | 67 ++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the 5-stage MIPS core, plus the EX/MEM latch record.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef enum logic [5:0] {
        RTYPE = 6'h00, J    = 6'h02, JAL  = 6'h03, BEQ  = 6'h04, BNE = 6'h05,
        ADDI  = 6'h08, ADDIU = 6'h09, SLTI = 6'h0A, ANDI = 6'h0C, ORI = 6'h0D,
        LUI   = 6'h0F, LW   = 6'h23, SW   = 6'h2B, HALT = 6'h3F
    } opcode_t;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} exmem_state_t;
    typedef struct packed {
        logic       RegWrite;
        logic       dWEN;
        logic       dREN;
        logic       Halt;
        logic [1:0] MemtoReg;
        opcode_t    opcode;
        regbits_t   wsel;
        word_t      aluout;
        word_t      rdat2;
        word_t      pcp4;
        word_t      extImm;
    } exmem_t;
endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX/MEM pipeline latch signals, data-cache request strobes and hazard busy.
interface ex_mem_if;
    import cpu_types_pkg::*;
    logic ihit, dhit, flush;
    logic RegWrite_in, dWEN_in, dREN_in, Halt_in;
    logic [1:0] MemtoReg_in;
    opcode_t opcode_in;
    regbits_t wsel_in;
    word_t aluout_in, rdat2_in, pcp4_in, extImm_in, dmemload;
    logic RegWrite_out, Halt_out;
    logic [1:0] MemtoReg_out;
    opcode_t opcode_out;
    regbits_t wsel_out;
    word_t aluout_out, rdat2_out, pcp4_out, extImm_out;
    logic dmemREN, dmemWEN, busy;
    word_t dmemaddr, dmemstore, dload_out;

    modport ex_mem_reg (
        input  ihit, dhit, flush, dmemload,
        input  RegWrite_in, dWEN_in, dREN_in, Halt_in, MemtoReg_in, opcode_in, wsel_in,
        input  aluout_in, rdat2_in, pcp4_in, extImm_in,
        output RegWrite_out, Halt_out, MemtoReg_out, opcode_out, wsel_out,
        output aluout_out, rdat2_out, pcp4_out, extImm_out,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dload_out, busy
    );
    modport tb (
        output ihit, dhit, flush, dmemload,
        output RegWrite_in, dWEN_in, dREN_in, Halt_in, MemtoReg_in, opcode_in, wsel_in,
        output aluout_in, rdat2_in, pcp4_in, extImm_in,
        input  RegWrite_out, Halt_out, MemtoReg_out, opcode_out, wsel_out,
        input  aluout_out, rdat2_out, pcp4_out, extImm_out,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dload_out, busy
    );
endinterface

// File: rtl/dmem_req_fsm.sv
// dmem_req_fsm: tracks the outstanding data-memory request and decodes busy and the cache strobes.
module dmem_req_fsm
    import cpu_types_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic advance,
    input  logic flush,
    input  logic mem_op,
    input  logic dhit,
    input  logic dren,
    input  logic dwen,
    output logic busy,
    output logic dmemREN,
    output logic dmemWEN
);
    exmem_state_t state;

    assign busy    = state == REQ;
    assign dmemWEN = busy & dwen;
    assign dmemREN = busy & dren & ~dwen;

    // flush arrives pre-gated: it is only ever high outside REQ and while not frozen
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else if (busy) state <= dhit ? DONE : REQ;
        else if (flush) state <= IDLE;
        else if (advance) state <= mem_op ? REQ : IDLE;
    end
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline latch that also owns the data-memory request and captures load data.
module ex_mem_reg
    import cpu_types_pkg::*;
#(
    parameter bit HALT_STICKY = 1'b1
) (
    input logic CLK,
    input logic nRST,
    ex_mem_if.ex_mem_reg emif
);
    exmem_t r, d;
    word_t dload;
    logic busy, frozen, advance, bubble;

    assign d = '{RegWrite: emif.RegWrite_in, dWEN: emif.dWEN_in, dREN: emif.dREN_in,
                 Halt: emif.Halt_in, MemtoReg: emif.MemtoReg_in, opcode: emif.opcode_in,
                 wsel: emif.wsel_in, aluout: emif.aluout_in, rdat2: emif.rdat2_in,
                 pcp4: emif.pcp4_in, extImm: emif.extImm_in};

    assign frozen  = HALT_STICKY && r.Halt;
    assign advance = emif.ihit & ~busy & ~frozen;
    assign bubble  = emif.flush & ~busy & ~frozen;

    dmem_req_fsm u_fsm (
        .CLK     (CLK),
        .nRST    (nRST),
        .advance (advance),
        .flush   (bubble),
        .mem_op  (emif.dREN_in | emif.dWEN_in),
        .dhit    (emif.dhit),
        .dren    (r.dREN),
        .dwen    (r.dWEN),
        .busy    (busy),
        .dmemREN (emif.dmemREN),
        .dmemWEN (emif.dmemWEN)
    );

    // load data is only taken while the read strobe is actually out
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r     <= '0;
            dload <= '0;
        end else if (bubble) begin
            r     <= '0;
            dload <= '0;
        end else if (advance) begin
            r     <= d;
            dload <= '0;
        end else if (emif.dmemREN && emif.dhit) begin
            dload <= emif.dmemload;
        end
    end

    assign emif.RegWrite_out = r.RegWrite;
    assign emif.Halt_out     = r.Halt;
    assign emif.MemtoReg_out = r.MemtoReg;
    assign emif.opcode_out   = r.opcode;
    assign emif.wsel_out     = r.wsel;
    assign emif.aluout_out   = r.aluout;
    assign emif.rdat2_out    = r.rdat2;
    assign emif.pcp4_out     = r.pcp4;
    assign emif.extImm_out   = r.extImm;
    assign emif.dmemaddr     = r.aluout;
    assign emif.dmemstore    = r.rdat2;
    assign emif.dload_out    = dload;
    assign emif.busy         = busy;
endmodule
